// File: rtl/mips_pkg.sv
// Shared definitions for the single-cycle MIPS core.
//   pc_state_t       : sequencer states (boot, run, halted, fault)
//   INSTR_BYTES      : instruction size in bytes
//   DEFAULT_RESET_PC : default reset vector
package mips_pkg;

  typedef enum logic [1:0] {
    StBoot   = 2'd0,
    StRun    = 2'd1,
    StHalted = 2'd2,
    StFault  = 2'd3
  } pc_state_t;

  localparam int unsigned INSTR_BYTES      = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection.
//   pc_plus4      in  : sequential successor of the current pc
//   branch_taken  in  : branch condition true
//   jump          in  : J/JAL selected
//   jump_reg      in  : JR selected
//   branch_off_sh in  : sign-extended offset, already << 2
//   jump_tgt_sh   in  : 26-bit target, already << 2
//   jr_target     in  : register value for JR
//   next_pc       out : selected next pc (jump_reg > jump > branch > sequential)
//   misaligned    out : JR selected with a non-word-aligned target
module pc_next_sel (
  input  logic [31:0] pc_plus4,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] branch_off_sh,
  input  logic [27:0] jump_tgt_sh,
  input  logic [31:0] jr_target,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  always_comb begin
    next_pc = pc_plus4;
    if (jump_reg) begin
      next_pc = jr_target;
    end else if (jump) begin
      next_pc = {pc_plus4[31:28], jump_tgt_sh};
    end else if (branch_taken) begin
      // Wraps modulo 2^32; overflow is not architecturally visible here.
      next_pc = pc_plus4 + branch_off_sh;
    end
  end

  assign misaligned = jump_reg && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: holds the PC, picks the next PC, sequences
// boot/run/halted/fault and counts retired instructions.
//   clk, reset (sync, active-high)
//   stall, halt, branch_taken, jump, jump_reg : control inputs
//   branch_off_sh, jump_tgt_sh, jr_target     : redirect targets
//   pc, pc_plus4                              : current pc and its successor
//   fetch_valid                               : pc addresses a real instruction
//   fault                                     : sticky misaligned-JR flag
//   retired                                   : retired-instruction counter
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             halt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jump_reg,
  input  logic [31:0]      branch_off_sh,
  input  logic [27:0]      jump_tgt_sh,
  input  logic [31:0]      jr_target,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic             fault,
  output logic [CNT_W-1:0] retired
);

  pc_state_t        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             fault_q, fault_d;
  logic             fetch_valid_q;
  logic [31:0]      next_pc;
  logic             misaligned;

  assign pc_plus4 = pc_q + 32'(INSTR_BYTES);

  pc_next_sel u_next_sel (
    .pc_plus4      (pc_plus4),
    .branch_taken  (branch_taken),
    .jump          (jump),
    .jump_reg      (jump_reg),
    .branch_off_sh (branch_off_sh),
    .jump_tgt_sh   (jump_tgt_sh),
    .jr_target     (jr_target),
    .next_pc       (next_pc),
    .misaligned    (misaligned)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        // Stall outranks everything, including halt and fault detection.
        if (!stall) begin
          if (halt) begin
            retired_d = retired_q + 1'b1;
            state_d   = StHalted;
          end else if (misaligned) begin
            fault_d = 1'b1;
            state_d = StFault;
          end else begin
            pc_d      = {next_pc[31:2], 2'b00};
            retired_d = retired_q + 1'b1;
          end
        end
      end
      // Halted and fault are terminal until reset.
      StHalted, StFault: ;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StBoot;
      pc_q          <= {RESET_PC[31:2], 2'b00};
      retired_q     <= '0;
      fault_q       <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      retired_q     <= retired_d;
      fault_q       <= fault_d;
      fetch_valid_q <= (state_d == StRun);
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign fault       = fault_q;
  assign retired     = retired_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter stage of the single-cycle MIPS core. It holds the architectural PC and computes PC+4. Each cycle it selects the next PC from four sources: sequential, branch, jump, or jump-register. The branch and jump targets it consumes arrive already shifted left by 2 from the upstream shift-left-2 stages. It also sequences boot, halt and fault states, flags when fetch is valid, and counts retired instructions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and counter this cycle.
- halt  in  1  current instruction is a halt; decoded elsewhere.
- branch_taken  in  1  branch condition true (Branch & Zero).
- jump  in  1  J/JAL selected.
- jump_reg  in  1  JR selected.
- branch_off_sh  in  32  sign-extended immediate, already << 2.
- jump_tgt_sh  in  28  26-bit target, already << 2.
- jr_target  in  32  register-file value for JR.
- pc  out  32  current PC.
- pc_plus4  out  32  pc + 4, combinational from pc.
- fetch_valid  out  1  pc addresses a real instruction this cycle.
- fault  out  1  sticky misaligned-JR fault.
- retired  out  CNT_W  count of retired instructions.

## Operation
- States: BOOT, RUN, HALTED, FAULT.
- Reset values:
  - state = BOOT.
  - pc = RESET_PC.
  - fetch_valid = 0.
  - fault = 0.
  - retired = 0.
- BOOT: fetch_valid = 0, pc held; goes to RUN on the next edge unconditionally.
- RUN: fetch_valid = 1. On each edge with stall = 0:
  - pc ← next_pc.
  - retired ← retired + 1, wrapping from all-ones to 0.
- next_pc priority (highest first):
  - jump_reg → jr_target.
  - jump → {pc_plus4[31:28], jump_tgt_sh}.
  - branch_taken → pc_plus4 + branch_off_sh, modulo 2^32 with no overflow detection.
  - otherwise → pc_plus4.
- Simultaneous select inputs are a decode error upstream; the fixed priority above still applies.
- Misaligned JR: jump_reg = 1 with jr_target[1:0] ≠ 0, in RUN, stall = 0:
  - pc is not updated.
  - retired is not incremented.
  - fault ← 1.
  - state ← FAULT.
- Halt: halt = 1 in RUN with stall = 0:
  - retired increments.
  - pc holds.
  - state ← HALTED.
  - halt outranks every next-PC source.
- stall = 1 outranks halt, jumps, branches and fault detection; no state changes that cycle.
- HALTED and FAULT: fetch_valid = 0, all inputs ignored, pc and retired frozen. Only reset exits these states.
- Reset mid-operation, in any state and regardless of any other input, restores all reset values on that edge.
- pc[1:0] is always 0.

## Timing
- Redirect latency is 1 cycle: selection inputs sampled at edge N appear on pc immediately after edge N.
- pc_plus4 and next_pc are combinational.
- pc, fetch_valid, fault, retired and state are registered.
- After reset deasserts:
  - One BOOT cycle with fetch_valid = 0.
  - The first instruction at RESET_PC is valid in the following cycle.
- fault asserts in the cycle after the offending edge and stays high until reset.

## Structure
- Shared package `mips_pkg` holds:
  - enum `pc_state_t` (BOOT, RUN, HALTED, FAULT).
  - `INSTR_BYTES` = 4.
  - default reset vector constant `DEFAULT_RESET_PC`.
- Sub-module `pc_next_sel`: purely combinational next-PC mux/adder. Inputs are pc_plus4, the select bits and the three targets; outputs are next_pc and misaligned.
- Top level keeps the state register, PC register and counter.

## Test plan
- Reset then release, RESET_PC = 0x0040_0000:
  - Cycle 1: fetch_valid = 0, pc = 0x0040_0000.
  - Cycle 2: fetch_valid = 1.
  - After 3 unstalled cycles: pc = 0x0040_000C, retired = 3.
- Backward branch: pc = 0x0040_0010, branch_taken = 1, branch_off_sh = 0xFFFF_FFF0 → pc = 0x0040_0004.
- Jump: pc = 0x1000_0000, jump = 1, jump_tgt_sh = 0x0000_0100 → pc = 0x1000_0100.
- Priority: jump_reg = 1 (jr_target = 0x0000_2000) with jump = 1 and branch_taken = 1 in the same cycle → pc = 0x0000_2000.
- Misaligned JR: jr_target = 0x0000_2002 → pc unchanged, fault = 1 next cycle, fetch_valid = 0. A following reset clears fault.
- Stall and halt:
  - stall = 1 with halt = 1 for 2 cycles → pc and retired unchanged, state RUN.
  - Then stall = 0 → HALTED, retired + 1, pc frozen.
  - Reset while HALTED → BOOT.
